// File: rtl/mem_req_arbiter.sv
// Two-port request arbiter in front of the PSRAM controller: port A (CPU, rd/wr), port B (VIC, rd only).
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise B has fixed priority over A.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH      = 24,
  parameter int DATA_WIDTH      = 8,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic                  i_clkRAM,
  input  logic                  reset,
  input  logic                  i_a_req,
  input  logic                  i_a_write,
  input  logic [ADDR_WIDTH-1:0] i_a_address,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  output logic                  o_a_ack,
  output logic [DATA_WIDTH-1:0] o_a_data,
  input  logic                  i_b_req,
  input  logic [ADDR_WIDTH-1:0] i_b_address,
  output logic                  o_b_ack,
  output logic [DATA_WIDTH-1:0] o_b_data,
  output logic                  o_mem_cs,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic                  i_mem_busy,
  input  logic                  i_mem_dataReady,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_err
);

  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESPOND
  } state_t;

  state_t                state_q, state_d;
  logic                  grant_b_q, grant_b_d;
  logic                  cs_q, cs_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic                  err_q, err_d;
  logic                  got_q, got_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  logic issue_go;
  logic pick_b;
  logic wd_done;
  logic to_respond;

  assign issue_go = (state_q == IDLE) && !i_mem_busy && (i_a_req || i_b_req);
  assign wd_done  = (wd_q == WD_W'(WATCHDOG_CYCLES - 1));

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q names the port preferred on the next conflict; it flips on every grant.
  logic rr_q, rr_d;

  assign pick_b = i_b_req && (!i_a_req || rr_q);
  assign rr_d   = rr_q ^ issue_go;

  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign pick_b = i_b_req;
`endif

  always_comb begin
    state_d    = state_q;
    grant_b_d  = grant_b_q;
    cs_d       = 1'b1;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    err_d      = err_q;
    got_d      = got_q;
    wd_d       = wd_q;
    to_respond = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue_go) begin
          grant_b_d = pick_b;
          cs_d      = 1'b0;
          state_d   = ISSUE;
          if (pick_b) begin
            write_d = 1'b0;
            addr_d  = i_b_address;
            wdata_d = '0;
          end else begin
            write_d = i_a_write;
            addr_d  = i_a_address;
            wdata_d = i_a_data;
          end
        end
      end

      ISSUE: begin
        state_d = WAIT_START;
        wd_d    = '0;
      end

      WAIT_START: begin
        if (i_mem_busy) begin
          state_d = WAIT_DONE;
          wd_d    = '0;
          got_d   = 1'b0;
        end else if (wd_done) begin
          err_d      = 1'b1;
          to_respond = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!write_q && i_mem_dataReady) begin
          got_d = 1'b1;
          if (grant_b_q) begin
            b_data_d = i_mem_data;
          end else begin
            a_data_d = i_mem_data;
          end
        end
        // A read that finishes without ever presenting data counts as an abort.
        if (!i_mem_busy) begin
          to_respond = 1'b1;
          if (!write_q && !got_q && !i_mem_dataReady) begin
            err_d = 1'b1;
          end
        end else if (wd_done) begin
          err_d      = 1'b1;
          to_respond = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      RESPOND: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (to_respond) begin
      state_d = RESPOND;
      a_ack_d = !grant_b_q;
      b_ack_d = grant_b_q;
    end
  end

  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_b_q <= 1'b0;
      cs_q      <= 1'b1;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      got_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_b_q <= grant_b_d;
      cs_q      <= cs_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      err_q     <= err_d;
      got_q     <= got_d;
      wd_q      <= wd_d;
    end
  end

  assign o_mem_cs      = cs_q;
  assign o_mem_write   = write_q;
  assign o_mem_address = addr_q;
  assign o_mem_data    = wdata_q;
  assign o_a_ack       = a_ack_q;
  assign o_b_ack       = b_ack_q;
  assign o_a_data      = a_data_q;
  assign o_b_data      = b_data_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter with a behavioural memCtrl model.
// Expected transactions are queued when requests are raised and retired on each ack.
`timescale 1ns/1ps
module tb_mem_req_arbiter;
  localparam int AW = 24;
  localparam int DW = 8;
  localparam int WD = 64;
  localparam int M_NORMAL  = 0;
  localparam int M_NO_BUSY = 1;
  localparam int M_NO_DR   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          i_a_req, i_a_write, i_b_req;
  logic [AW-1:0] i_a_address, i_b_address;
  logic [DW-1:0] i_a_data;
  logic          o_a_ack, o_b_ack, o_mem_cs, o_mem_write, o_err;
  logic [DW-1:0] o_a_data, o_b_data, o_mem_data;
  logic [AW-1:0] o_mem_address;
  logic          init_busy, m_busy, m_dr;
  logic [DW-1:0] m_rdata;
  logic          mem_busy;

  assign mem_busy = init_busy | m_busy;

  mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WATCHDOG_CYCLES(WD)) dut (
    .i_clkRAM(clk), .reset(rst_n),
    .i_a_req(i_a_req), .i_a_write(i_a_write), .i_a_address(i_a_address), .i_a_data(i_a_data),
    .o_a_ack(o_a_ack), .o_a_data(o_a_data),
    .i_b_req(i_b_req), .i_b_address(i_b_address), .o_b_ack(o_b_ack), .o_b_data(o_b_data),
    .o_mem_cs(o_mem_cs), .o_mem_write(o_mem_write), .o_mem_address(o_mem_address),
    .o_mem_data(o_mem_data), .i_mem_busy(mem_busy), .i_mem_dataReady(m_dr),
    .i_mem_data(m_rdata), .o_err(o_err)
  );

  typedef struct {
    logic          port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          abort;
    logic          err;
    logic          lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ram     [logic [AW-1:0]];
  logic [DW-1:0] ref_ram [logic [AW-1:0]];
  int            errs, checks;
  int            mode, busy_len, m_cnt, cs_cnt;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic          cs_prev, busy_prev, err_sh;
  logic [DW-1:0] cur_a, cur_b;
`ifdef ARB_ROUND_ROBIN_EN
  logic          ptr;
`endif

  function automatic logic [DW-1:0] dflt(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(logic port, logic wr, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                          logic abort, logic lat);
    exp_t e;
    e.port  = port;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = ref_ram.exists(addr) ? ref_ram[addr] : dflt(addr);
    if (wr) ref_ram[addr] = wdata;
    err_sh  = err_sh | abort;
    e.abort = abort;
    e.err   = err_sh;
    e.lat   = lat;
`ifdef ARB_ROUND_ROBIN_EN
    ptr = ~ptr;
`endif
    exp_q.push_back(e);
  endtask

  // memCtrl model: busy one cycle after cs, dataReady on the last busy cycle of a read.
  task automatic model_step();
    if (!rst_n) begin
      m_busy = 1'b0;
      m_dr   = 1'b0;
      m_cnt  = 0;
    end else begin
      m_dr = 1'b0;
      if (m_cnt != 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
        end else if (m_cnt == 1 && !m_wr && mode != M_NO_DR) begin
          m_dr    = 1'b1;
          m_rdata = ram.exists(m_addr) ? ram[m_addr] : dflt(m_addr);
        end
      end else if (!o_mem_cs) begin
        m_wr   = o_mem_write;
        m_addr = o_mem_address;
        if (o_mem_write) ram[o_mem_address] = o_mem_data;
        if (mode != M_NO_BUSY) begin
          m_busy = 1'b1;
          m_cnt  = busy_len;
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!o_mem_cs) begin
      cs_cnt++;
      check("cs_one_cycle", 32'(cs_prev), 32'd1);
      check("cs_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("mem_write", 32'(o_mem_write), 32'(exp_q[0].wr));
        check("mem_addr", 32'(o_mem_address), 32'(exp_q[0].addr));
        if (exp_q[0].wr) check("mem_data", 32'(o_mem_data), 32'(exp_q[0].wdata));
      end
    end
    if (o_a_ack || o_b_ack) begin
      check("ack_excl", 32'(o_a_ack && o_b_ack), 32'd0);
      check("ack_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_port", 32'(o_b_ack), 32'(e.port));
        check("cs_per_txn", 32'(cs_cnt), 32'd1);
        check("err_flag", 32'(o_err), 32'(e.err));
        if (e.lat) check("ack_latency", 32'(busy_prev), 32'd1);
        if (!e.wr && !e.abort) begin
          if (e.port) cur_b = e.rdata;
          else        cur_a = e.rdata;
        end
        check("a_data", 32'(o_a_data), 32'(cur_a));
        check("b_data", 32'(o_b_data), 32'(cur_b));
      end
      cs_cnt = 0;
    end
    cs_prev   = o_mem_cs;
    busy_prev = mem_busy;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic wait_acks(int n, int budget, output int elapsed);
    int got = 0;
    elapsed = 0;
    while (got < n && elapsed < budget) begin
      tick();
      elapsed++;
      if (o_a_ack || o_b_ack) got++;
    end
    check("ack_wait", 32'(got), 32'(n));
  endtask

  task automatic do_req(logic port, logic wr, logic [AW-1:0] addr, logic [DW-1:0] data,
                        logic abort, logic lat, output int elapsed);
    push_exp(port, wr, addr, data, abort, lat);
    if (port) begin
      i_b_req     = 1'b1;
      i_b_address = addr;
    end else begin
      i_a_req     = 1'b1;
      i_a_write   = wr;
      i_a_address = addr;
      i_a_data    = data;
    end
    wait_acks(1, 200, elapsed);
    i_a_req = 1'b0;
    i_b_req = 1'b0;
  endtask

  initial begin
    int n, lows;
    logic w;
    errs = 0; checks = 0; cs_cnt = 0;
    rst_n = 1'b0; init_busy = 1'b1; m_busy = 1'b0; m_dr = 1'b0; m_rdata = '0;
    m_cnt = 0; m_wr = 1'b0; m_addr = '0;
    mode = M_NORMAL; busy_len = 4;
    i_a_req = 1'b0; i_a_write = 1'b0; i_a_address = '0; i_a_data = '0;
    i_b_req = 1'b0; i_b_address = '0;
    cs_prev = 1'b1; busy_prev = 1'b0; err_sh = 1'b0; cur_a = '0; cur_b = '0;
`ifdef ARB_ROUND_ROBIN_EN
    ptr = 1'b0;
`endif
    repeat (3) tick();
    check("rst_cs", 32'(o_mem_cs), 32'd1);
    check("rst_acks", 32'({o_a_ack, o_b_ack}), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_mem", 32'({o_mem_write, o_mem_address}), 32'd0);
    check("rst_mem_data", 32'(o_mem_data), 32'd0);
    check("rst_rdata", 32'({o_a_data, o_b_data}), 32'd0);

    // busy held high after reset release: no issue until it clears
    push_exp(1'b0, 1'b0, 24'h000010, 8'h00, 1'b0, 1'b1);
    i_a_req = 1'b1; i_a_write = 1'b0; i_a_address = 24'h000010;
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!o_mem_cs) lows++;
    end
    check("cs_held_busy", 32'(lows), 32'd0);
    init_busy = 1'b0;
    wait_acks(1, 50, n);
    i_a_req = 1'b0;
    tick();

    do_req(1'b0, 1'b1, 24'h00AAAA, 8'hF0, 1'b0, 1'b1, n);
    tick();
    ram[24'h000400] = 8'h5A;
    ref_ram[24'h000400] = 8'h5A;
    do_req(1'b1, 1'b0, 24'h000400, 8'h00, 1'b0, 1'b1, n);
    check("b_read_5a", 32'(o_b_data), 32'h5A);
    tick();

    // simultaneous requests held across several transactions
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      w = ptr;
`else
      w = 1'b1;
`endif
      push_exp(w, 1'b0, w ? 24'h000400 : 24'h001234, 8'h00, 1'b0, 1'b1);
    end
    i_a_req = 1'b1; i_a_write = 1'b0; i_a_address = 24'h001234;
    i_b_req = 1'b1; i_b_address = 24'h000400;
    wait_acks(4, 200, n);
    i_b_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    i_a_req = 1'b0;
`else
    push_exp(1'b0, 1'b0, 24'h001234, 8'h00, 1'b0, 1'b1);
    wait_acks(1, 50, n);
    i_a_req = 1'b0;
`endif
    tick();
    do_req(1'b0, 1'b0, 24'h00AAAA, 8'h00, 1'b0, 1'b1, n);
    check("a_readback", 32'(o_a_data), 32'hF0);
    tick();

    // memCtrl never answers: watchdog abort
    mode = M_NO_BUSY;
    do_req(1'b0, 1'b0, 24'h000020, 8'h00, 1'b1, 1'b0, n);
    check("wd_window", 32'(n >= WD && n <= WD + 4), 32'd1);
    mode = M_NORMAL;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_a_ack || o_b_ack || !o_mem_cs) lows++;
    end
    check("wd_quiet", 32'(lows), 32'd0);
    do_req(1'b1, 1'b0, 24'h000400, 8'h00, 1'b0, 1'b1, n);

    // reset while waiting for busy to fall
    busy_len = 20;
    push_exp(1'b0, 1'b0, 24'h000030, 8'h00, 1'b0, 1'b1);
    i_a_req = 1'b1; i_a_write = 1'b0; i_a_address = 24'h000030;
    n = 0;
    while (o_mem_cs && n < 20) begin
      tick();
      n++;
    end
    check("pre_rst_cs", 32'(o_mem_cs), 32'd0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs", 32'(o_mem_cs), 32'd1);
    check("mid_rst_acks", 32'({o_a_ack, o_b_ack}), 32'd0);
    check("mid_rst_err", 32'(o_err), 32'd0);
    exp_q.delete();
    cs_cnt = 0; err_sh = 1'b0; cur_a = '0; cur_b = '0;
`ifdef ARB_ROUND_ROBIN_EN
    ptr = 1'b0;
`endif
    i_a_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    busy_len = 4;
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_a_ack || o_b_ack || !o_mem_cs) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);
    do_req(1'b0, 1'b1, 24'h000050, 8'h77, 1'b0, 1'b1, n);
    tick();
    do_req(1'b0, 1'b0, 24'h000050, 8'h00, 1'b0, 1'b1, n);
    check("post_rst_read", 32'(o_a_data), 32'h77);
    tick();

    // read whose busy falls without dataReady
    mode = M_NO_DR;
    do_req(1'b1, 1'b0, 24'h000060, 8'h00, 1'b1, 1'b1, n);
    mode = M_NORMAL;
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
